// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   typedef enum logic [1:0] {
      START    = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } state_t;

   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl;

   function automatic stage_ctrl mk_stage(input logic en, input logic flush);
      stage_ctrl s;
      s.en    = en;
      s.flush = flush;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use hazard term between the EX load and ID reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             lu
);

   logic w_rs_hit;
   logic w_rt_hit;
   logic w_dst_live;

   // A load into $zero never produces a value worth waiting for.
   assign w_dst_live = (ex_rt != REG_W'(REG_ZERO));
   assign w_rs_hit   = (ex_rt == id_rs);
   assign w_rt_hit   = id_uses_rt & (ex_rt == id_rt);
   assign lu         = ex_mem_read & w_dst_live & (w_rs_hit | w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Stall/flush sequencer for the 5-stage pipeline; optional perf
//          counters enabled by PIPE_CTRL_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int REG_W       = 5,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             mem_branch,
   input  logic             mem_alu_zero,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             pc_sel_branch,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mem_err
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
`endif
);

   localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

   if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
      $error("pipe_hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic [c_WAIT_W-1:0] w_wait_nxt;
   logic                r_mem_err;
   logic                w_err_nxt;

   logic      w_mem_acc;
   logic      w_taken;
   logic      w_lu;
   logic      w_advance;

   logic      w_adv_pc_en;
   logic      w_adv_pc_sel;
   logic      w_adv_memwb_en;
   stage_ctrl w_adv_ifid;
   stage_ctrl w_adv_idex;
   stage_ctrl w_adv_exmem;

   logic      w_dmem_req;
   logic      w_pc_en;
   logic      w_pc_sel;
   logic      w_memwb_en;
   stage_ctrl w_ifid;
   stage_ctrl w_idex;
   stage_ctrl w_exmem;

   assign w_mem_acc = mem_read | mem_write;
   assign w_taken   = mem_branch & mem_alu_zero;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .lu          (w_lu)
   );

   // Normal-advance decision shared by RUN and the ready cycle of MEM_WAIT.
   always_comb begin
      w_adv_pc_en    = 1'b1;
      w_adv_pc_sel   = 1'b0;
      w_adv_memwb_en = 1'b1;
      w_adv_ifid     = mk_stage(1'b1, 1'b0);
      w_adv_idex     = mk_stage(1'b1, 1'b0);
      w_adv_exmem    = mk_stage(1'b1, 1'b0);
      if (w_taken) begin
         w_adv_pc_sel = 1'b1;
         w_adv_ifid   = mk_stage(1'b1, 1'b1);
         w_adv_idex   = mk_stage(1'b1, 1'b1);
         w_adv_exmem  = mk_stage(1'b1, 1'b1);
      end else if (w_lu) begin
         w_adv_pc_en = 1'b0;
         w_adv_ifid  = mk_stage(1'b0, 1'b0);
         w_adv_idex  = mk_stage(1'b1, 1'b1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= START;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_mem_err  <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_err_nxt   = r_mem_err;
      w_advance   = 1'b0;
      w_dmem_req  = 1'b0;
      w_pc_en     = 1'b0;
      w_pc_sel    = 1'b0;
      w_memwb_en  = 1'b0;
      w_ifid      = mk_stage(1'b0, 1'b0);
      w_idex      = mk_stage(1'b0, 1'b0);
      w_exmem     = mk_stage(1'b0, 1'b0);

      if (!rst) begin
         case (r_state)
            START: begin
               w_memwb_en  = 1'b1;
               w_ifid      = mk_stage(1'b1, 1'b1);
               w_idex      = mk_stage(1'b1, 1'b1);
               w_exmem     = mk_stage(1'b1, 1'b1);
               w_state_nxt = RUN;
            end
            RUN: begin
               w_dmem_req = w_mem_acc;
               if (w_mem_acc && !dmem_ready) begin
                  w_state_nxt = MEM_WAIT;
                  w_wait_nxt  = c_WAIT_W'(1);
               end else begin
                  w_advance = 1'b1;
               end
            end
            MEM_WAIT: begin
               w_dmem_req = 1'b1;
               if (dmem_ready) begin
                  w_advance   = 1'b1;
                  w_state_nxt = RUN;
                  w_wait_nxt  = '0;
               end else if (r_wait_cnt == c_WAIT_W'(MEM_TIMEOUT - 1)) begin
                  // The RUN cycle already counted one; this is unanswered cycle MEM_TIMEOUT.
                  w_state_nxt = ERR;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
               end
            end
            ERR: begin
               w_state_nxt = ERR;
            end
            default: begin
               w_state_nxt = START;
            end
         endcase

         if (w_advance) begin
            w_pc_en    = w_adv_pc_en;
            w_pc_sel   = w_adv_pc_sel;
            w_memwb_en = w_adv_memwb_en;
            w_ifid     = w_adv_ifid;
            w_idex     = w_adv_idex;
            w_exmem    = w_adv_exmem;
         end
      end
   end

   assign dmem_req      = w_dmem_req;
   assign pc_en         = w_pc_en;
   assign pc_sel_branch = w_pc_sel;
   assign ifid_en       = w_ifid.en;
   assign ifid_flush    = w_ifid.flush;
   assign idex_en       = w_idex.en;
   assign idex_flush    = w_idex.flush;
   assign exmem_en      = w_exmem.en;
   assign exmem_flush   = w_exmem.flush;
   assign memwb_en      = w_memwb_en;
   assign mem_err       = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_events;
   logic             w_in_pipe;

   assign w_in_pipe = (r_state == RUN) || (r_state == MEM_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (w_in_pipe && !w_pc_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (w_pc_sel && (r_flush_events != '1)) begin
            r_flush_events <= r_flush_events + CNT_W'(1);
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed plus random bench for pipe_hazard_ctrl against a
//          cycle-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int T  = 16;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] id_rs, id_rt, ex_rt;
   logic          id_uses_rt, ex_mem_read, mem_branch, mem_alu_zero;
   logic          mem_read, mem_write, dmem_ready;
   logic          dmem_req, pc_en, pc_sel_branch;
   logic          ifid_en, idex_en, exmem_en, memwb_en;
   logic          ifid_flush, idex_flush, exmem_flush, mem_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   stall_cycles, flush_events;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (T),
      .REG_W       (RW),
      .CNT_W       (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .ex_mem_read   (ex_mem_read),
      .ex_rt         (ex_rt),
      .mem_branch    (mem_branch),
      .mem_alu_zero  (mem_alu_zero),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .dmem_ready    (dmem_ready),
      .dmem_req      (dmem_req),
      .pc_en         (pc_en),
      .pc_sel_branch (pc_sel_branch),
      .ifid_en       (ifid_en),
      .idex_en       (idex_en),
      .exmem_en      (exmem_en),
      .memwb_en      (memwb_en),
      .ifid_flush    (ifid_flush),
      .idex_flush    (idex_flush),
      .exmem_flush   (exmem_flush),
      .mem_err       (mem_err)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles  (stall_cycles),
      .flush_events  (flush_events)
`endif
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   string phase    = "reset";

   // Model state: first cycle after reset, unanswered-request cycle count, sticky error.
   bit    m_start;
   int    m_wait;
   bit    m_err;
   int    m_stall;
   int    m_flush;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {dmem_req, pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, mem_err}
   function automatic logic [10:0] observed();
      return {dmem_req, pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, mem_err};
   endfunction

   function automatic logic [10:0] model_out();
      logic [10:0] v;
      logic acc, tk, lu;
      v = '0;
      if (rst) return v;
      if (m_err) begin
         v[0] = 1'b1;
         return v;
      end
      if (m_start) return 11'b0_0_0_1111_111_0;
      acc = mem_read | mem_write;
      tk  = mem_branch & mem_alu_zero;
      lu  = ex_mem_read && (ex_rt != 0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (!dmem_ready && (m_wait > 0 || acc)) return 11'b1_0_0_0000_000_0;
      v[10] = (m_wait > 0) | acc;
      if (tk)      v[9:1] = 9'b1_1_1111_111;
      else if (lu) v[9:1] = 9'b0_0_0111_010;
      else         v[9:1] = 9'b1_0_1111_000;
      return v;
   endfunction

   task automatic model_reset();
      m_start = 1'b1;
      m_wait  = 0;
      m_err   = 1'b0;
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic model_update(input logic [10:0] v);
      if (rst) begin
         model_reset();
      end else if (m_start) begin
         m_start = 1'b0;
      end else if (!m_err) begin
         if (!v[9]) m_stall++;
         if (v[8])  m_flush++;
         if (!dmem_ready && (m_wait > 0 || mem_read || mem_write)) begin
            m_wait++;
            if (m_wait >= T) m_err = 1'b1;
         end else begin
            m_wait = 0;
         end
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked on the falling edge.
   task automatic cycle();
      logic [10:0] v;
      @(negedge clk);
      v = model_out();
      check(phase, 32'(observed()), 32'(v));
`ifdef PIPE_CTRL_PERF_EN
      check({phase, "_stall_cnt"}, stall_cycles, 32'(m_stall));
      check({phase, "_flush_cnt"}, flush_events, 32'(m_flush));
`endif
      @(posedge clk);
      model_update(v);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; ex_rt = '0;
      id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      mem_branch = 1'b0; mem_alu_zero = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      phase = "reset";
      rst = 1'b1;
      model_reset();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #1;

      do_reset();
      phase = "start";
      cycle();
      phase = "run_idle";
      repeat (3) cycle();

      phase = "lu_stall";
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      cycle();
      phase = "lu_resume";
      ex_mem_read = 1'b0;
      cycle();
      phase = "lu_zero_reg";
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      cycle();
      phase = "lu_rt";
      ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
      cycle();
      phase = "lu_rt_unused";
      id_uses_rt = 1'b0;
      cycle();

      phase = "taken_over_lu";
      ex_rt = 5'd8; id_rs = 5'd8;
      mem_branch = 1'b1; mem_alu_zero = 1'b1;
      cycle();
      phase = "not_taken";
      mem_alu_zero = 1'b0; ex_mem_read = 1'b0;
      cycle();
      idle_inputs();

      phase = "mem_wait";
      mem_read = 1'b1; dmem_ready = 1'b0;
      repeat (3) cycle();
      phase = "mem_ready";
      dmem_ready = 1'b1;
      cycle();
      phase = "mem_zero_lat";
      mem_read = 1'b0; mem_write = 1'b1;
      cycle();
      idle_inputs();
      cycle();

`ifdef PIPE_CTRL_PERF_EN
      do_reset();
      phase = "perf";
      cycle();
      ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
      cycle();
      idle_inputs();
      cycle();
      ex_mem_read = 1'b1; ex_rt = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1;
      cycle();
      idle_inputs();
      mem_branch = 1'b1; mem_alu_zero = 1'b1;
      cycle();
      idle_inputs();
      cycle();
      check("perf_stall_total", stall_cycles, 32'd2);
      check("perf_flush_total", flush_events, 32'd1);
`endif

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         ex_mem_read  = 1'($urandom_range(0, 1));
         ex_rt        = RW'($urandom_range(0, 3));
         id_rs        = RW'($urandom_range(0, 3));
         id_rt        = RW'($urandom_range(0, 3));
         id_uses_rt   = 1'($urandom_range(0, 1));
         mem_branch   = 1'($urandom_range(0, 1));
         mem_alu_zero = 1'($urandom_range(0, 1));
         mem_read     = ($urandom_range(0, 3) == 0);
         mem_write    = ($urandom_range(0, 3) == 0);
         dmem_ready   = ($urandom_range(0, 3) != 0);
         cycle();
      end
      idle_inputs();

      do_reset();
      phase = "timeout_start";
      cycle();
      phase = "timeout";
      mem_write = 1'b1; dmem_ready = 1'b0;
      repeat (T + 4) cycle();
      check("timeout_mem_err", 32'(mem_err), 32'd1);
      phase = "err_sticky";
      dmem_ready = 1'b1; mem_write = 1'b0;
      repeat (2) cycle();

      // Reset raised between edges must clear outputs immediately.
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_reset", 32'(observed()), 32'd0);
      @(posedge clk);
      #1;
      phase = "reset_hold";
      cycle();
      rst = 1'b0;

      phase = "wait_abandon_start";
      cycle();
      phase = "wait_abandon";
      mem_read = 1'b1; dmem_ready = 1'b0;
      repeat (3) cycle();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("abandon_req_drop", 32'(dmem_req), 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      rst = 1'b0;
      phase = "post_abandon_start";
      cycle();
      phase = "post_abandon_run";
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
